mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10000000, first word address of the data-memory window.
REQ-002 Parameter NUM_WORDS, default 4, number of 32-bit words in the window.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid_1 / req_valid_2  in  1 each  pipe-1 / pipe-2 memory request present; pipe 1 is older in program order.
REQ-006 req_we_1 / req_we_2  in  1 each  1 = store, 0 = load.
REQ-007 req_addr_1 / req_addr_2  in  32 each  byte address.
REQ-008 req_wdata_1 / req_wdata_2  in  32 each  store data.
REQ-009 Mem_rd_1 / Mem_rd_2  out  1 each  active-low read strobe to the data memory port.
REQ-010 Mem_wr_1 / Mem_wr_2  out  1 each  active-low write strobe to the data memory port.
REQ-011 Dir_Mem_1 / Dir_Mem_2  out  32 each  memory port address.
REQ-012 Dato_Mem_in_1 / Dato_Mem_in_2  out  32 each  memory port write data.
REQ-013 Dato_Mem_out_1 / Dato_Mem_out_2  in  32 each  memory port read data, combinational from the memory.
REQ-014 stall  out  1  freeze upstream pipeline; request inputs held stable while high.
REQ-015 rdata_1 / rdata_2  out  32 each  registered load result per pipe.
REQ-016 rvalid_1 / rvalid_2  out  1 each  one-cycle pulse, rdata_x valid.
REQ-017 addr_err_1 / addr_err_2  out  1 each  one-cycle pulse, request dropped for a bad address.

Function
REQ-018 Valid address: addr[1:0]==0 and BASE_ADDR <= addr <= BASE_ADDR+4*(NUM_WORDS-1); otherwise no strobe asserted, addr_err_x pulses the next cycle, and rvalid_x stays 0.
REQ-019 Strobes: load drives Mem_rd_x=0, Mem_wr_x=1; store drives Mem_wr_x=0, Mem_rd_x=1; idle port drives both 1, Dir_Mem_x=0, and Dato_Mem_in_x=0.
REQ-020 Never assert Mem_rd_x and Mem_wr_x low together.
REQ-021 Conflict: both valid, both addresses valid, equal word address (addr[31:2]), and at least one store.
REQ-022 Load/load to the same address is not a conflict; both issue in the same cycle.
REQ-023 FSM states: IDLE, SPLIT.
REQ-024 IDLE with no conflict: issue both valid requests on their own ports in the same cycle, stall=0, remain in IDLE.
REQ-025 IDLE with conflict: issue only pipe 1 on port 1, port 2 idle, stall=1 combinationally, go to SPLIT.
REQ-026 SPLIT: issue the held pipe-2 request on port 2, port 1 idle, stall=0, return to IDLE.
REQ-027 Ordering: a store then a load to the same address in a pair gives the load the new value; a store then a store leaves pipe-2 data in memory.
REQ-028 Load latency: rdata_x captures Dato_Mem_out_x at the end of the issue cycle; rvalid_x is high for exactly the following cycle.
REQ-029 rdata_x holds its last value when rvalid_x=0.
REQ-030 Each request issues exactly once; pipe 1 is not re-issued in SPLIT.
REQ-031 In SPLIT, the pipe-2 request is taken from the held inputs, which are guaranteed stable by stall.

Reset
REQ-032 rst=1 at a clock edge: state IDLE, rdata_1/2=0, rvalid_1/2=0, addr_err_1/2=0.
REQ-033 While rst=1: all strobes 1 (inactive), Dir_Mem_x=0, Dato_Mem_in_x=0, stall=0.
REQ-034 Reset during SPLIT abandons the pending pipe-2 request without issuing it.

Verification
REQ-035 Load 0x10000000 on pipe 1 and load 0x10000004 on pipe 2, memory initial 8/0xD -> same-cycle Mem_rd_1=Mem_rd_2=0, stall=0, next cycle rvalid_1/2=1, rdata_1=0x8, rdata_2=0xD.
REQ-036 Store 0x55 to 0x10000008 on pipe 1 and load 0x10000008 on pipe 2 -> cycle N: Mem_wr_1=0, stall=1; cycle N+1: Mem_rd_2=0; cycle N+2: rvalid_2=1, rdata_2=0x55.
REQ-037 Store 0xAA (pipe 1) and store 0xBB (pipe 2) to 0x1000000C -> two cycles, one stall cycle, then a load of 0x1000000C returns 0xBB.
REQ-038 Load 0x10000010 (pipe 1) and load 0x10000002 (pipe 2) -> no strobes, next cycle addr_err_1=addr_err_2=1, rvalid=0.
REQ-039 Conflict issued, rst=1 during SPLIT -> no port-2 strobe, next cycle IDLE with all outputs at reset values.
REQ-040 Load/load to 0x10000004 on both pipes -> single cycle, stall=0, rdata_1=rdata_2=0xD.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Dual-issue data-memory access controller. Two pipes (pipe 1 older than
// pipe 2) present one load/store request each per cycle. Both requests are
// issued on their own memory ports in the same cycle. The exception is a
// same-word pair that contains at least one store: that pair is split over
// two cycles, with pipe 1 issued first. The upstream pipeline is stalled for
// one cycle while the pair is split.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid_x/we_x/addr_x/wdata_x   request from pipe x (1 = older)
//   Mem_rd_x, Mem_wr_x           active-low strobes to memory port x
//   Dir_Mem_x, Dato_Mem_in_x     address / write data to memory port x
//   Dato_Mem_out_x               combinational read data from memory port x
//   stall                        freeze upstream; requests held while high
//   rdata_x, rvalid_x            registered load result and its 1-cycle pulse
//   addr_err_x                   1-cycle pulse: request dropped, bad address
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h10000000,
    parameter int          NUM_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_1,
    input  logic        req_valid_2,
    input  logic        req_we_1,
    input  logic        req_we_2,
    input  logic [31:0] req_addr_1,
    input  logic [31:0] req_addr_2,
    input  logic [31:0] req_wdata_1,
    input  logic [31:0] req_wdata_2,
    output logic        Mem_rd_1,
    output logic        Mem_rd_2,
    output logic        Mem_wr_1,
    output logic        Mem_wr_2,
    output logic [31:0] Dir_Mem_1,
    output logic [31:0] Dir_Mem_2,
    output logic [31:0] Dato_Mem_in_1,
    output logic [31:0] Dato_Mem_in_2,
    input  logic [31:0] Dato_Mem_out_1,
    input  logic [31:0] Dato_Mem_out_2,
    output logic        stall,
    output logic [31:0] rdata_1,
    output logic [31:0] rdata_2,
    output logic        rvalid_1,
    output logic        rvalid_2,
    output logic        addr_err_1,
    output logic        addr_err_2
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (NUM_WORDS - 1));

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    logic [0:0] state_reg, state_next;

    // Per-pipe views of the request/response signals (index 0 = pipe 1).
    logic [1:0]  valid, we, addr_ok, ok, issue, err_next;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] mem_out [2];
    logic [1:0]  rd_n, wr_n;
    logic [31:0] dir [2];
    logic [31:0] din [2];
    logic [31:0] rdata_reg [2];
    logic [1:0]  rvalid_reg, err_reg;
    logic        conflict;

    assign valid      = {req_valid_2, req_valid_1};
    assign we         = {req_we_2, req_we_1};
    assign addr[0]    = req_addr_1;
    assign addr[1]    = req_addr_2;
    assign wdata[0]   = req_wdata_1;
    assign wdata[1]   = req_wdata_2;
    assign mem_out[0] = Dato_Mem_out_1;
    assign mem_out[1] = Dato_Mem_out_2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_addr
            assign addr_ok[gi] = (addr[gi][1:0] == 2'b00) &&
                                 (addr[gi] >= BASE_ADDR) &&
                                 (addr[gi] <= LAST_ADDR);
            assign ok[gi]      = valid[gi] && addr_ok[gi];
        end
    endgenerate

    // Same-word pair with a store must be serialised to keep program order.
    // Two loads of the same word can safely share the cycle.
    assign conflict = ok[0] && ok[1] &&
                      (addr[0][31:2] == addr[1][31:2]) &&
                      (we[0] || we[1]);

    always_comb begin
        issue      = 2'b00;
        stall      = 1'b0;
        err_next   = 2'b00;
        state_next = state_reg;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    issue[0]   = ok[0];
                    issue[1]   = ok[1] && !conflict;
                    stall      = conflict;
                    err_next   = valid & ~addr_ok;
                    state_next = conflict ? SPLIT : IDLE;
                end
                SPLIT: begin
                    // Pipe 1 already went out; only the held pipe-2 request
                    // is issued now. It was address-checked when the
                    // conflict was detected, so no error can arise here.
                    issue[1]   = ok[1];
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // Strobes are mutually exclusive by construction: one is a
            // function of we, the other of its complement.
            assign rd_n[gi] = !(issue[gi] && !we[gi]);
            assign wr_n[gi] = !(issue[gi] && we[gi]);
            assign dir[gi]  = issue[gi] ? addr[gi] : 32'h0;
            assign din[gi]  = (issue[gi] && we[gi]) ? wdata[gi] : 32'h0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg[gi]  <= 32'h0;
                    rvalid_reg[gi] <= 1'b0;
                    err_reg[gi]    <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= issue[gi] && !we[gi];
                    err_reg[gi]    <= err_next[gi];
                    if (issue[gi] && !we[gi]) begin
                        rdata_reg[gi] <= mem_out[gi];
                    end
                end
            end
        end
    endgenerate

    assign Mem_rd_1      = rd_n[0];
    assign Mem_rd_2      = rd_n[1];
    assign Mem_wr_1      = wr_n[0];
    assign Mem_wr_2      = wr_n[1];
    assign Dir_Mem_1     = dir[0];
    assign Dir_Mem_2     = dir[1];
    assign Dato_Mem_in_1 = din[0];
    assign Dato_Mem_in_2 = din[1];
    assign rdata_1       = rdata_reg[0];
    assign rdata_2       = rdata_reg[1];
    assign rvalid_1      = rvalid_reg[0];
    assign rvalid_2      = rvalid_reg[1];
    assign addr_err_1    = err_reg[0];
    assign addr_err_2    = err_reg[1];

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl. A four-word behavioural data memory
// sits on both ports (reads combinational, writes on the rising edge, port 2
// written after port 1). Inputs change 1 time unit after a rising edge.
// Combinational outputs are checked 1 unit after that, and registered
// outputs are checked 1 unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_1, req_valid_2, req_we_1, req_we_2;
    logic [31:0] req_addr_1, req_addr_2, req_wdata_1, req_wdata_2;
    logic        Mem_rd_1, Mem_rd_2, Mem_wr_1, Mem_wr_2;
    logic [31:0] Dir_Mem_1, Dir_Mem_2, Dato_Mem_in_1, Dato_Mem_in_2;
    logic [31:0] Dato_Mem_out_1, Dato_Mem_out_2;
    logic        stall;
    logic [31:0] rdata_1, rdata_2;
    logic        rvalid_1, rvalid_2, addr_err_1, addr_err_2;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mem [4];
    logic        mem_init;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_1(req_valid_1), .req_valid_2(req_valid_2),
        .req_we_1(req_we_1), .req_we_2(req_we_2),
        .req_addr_1(req_addr_1), .req_addr_2(req_addr_2),
        .req_wdata_1(req_wdata_1), .req_wdata_2(req_wdata_2),
        .Mem_rd_1(Mem_rd_1), .Mem_rd_2(Mem_rd_2),
        .Mem_wr_1(Mem_wr_1), .Mem_wr_2(Mem_wr_2),
        .Dir_Mem_1(Dir_Mem_1), .Dir_Mem_2(Dir_Mem_2),
        .Dato_Mem_in_1(Dato_Mem_in_1), .Dato_Mem_in_2(Dato_Mem_in_2),
        .Dato_Mem_out_1(Dato_Mem_out_1), .Dato_Mem_out_2(Dato_Mem_out_2),
        .stall(stall),
        .rdata_1(rdata_1), .rdata_2(rdata_2),
        .rvalid_1(rvalid_1), .rvalid_2(rvalid_2),
        .addr_err_1(addr_err_1), .addr_err_2(addr_err_2)
    );

    // Behavioural data memory: words at 0x10000000..0x1000000C.
    assign Dato_Mem_out_1 = mem[Dir_Mem_1[3:2]];
    assign Dato_Mem_out_2 = mem[Dir_Mem_2[3:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            mem[0] <= 32'h8;
            mem[1] <= 32'hD;
            mem[2] <= 32'h0;
            mem[3] <= 32'h0;
        end else begin
            if (!Mem_wr_1) mem[Dir_Mem_1[3:2]] <= Dato_Mem_in_1;
            if (!Mem_wr_2) mem[Dir_Mem_2[3:2]] <= Dato_Mem_in_2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req1(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid_1 = v; req_we_1 = w; req_addr_1 = a; req_wdata_1 = d;
    endtask

    task automatic req2(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid_2 = v; req_we_2 = w; req_addr_2 = a; req_wdata_2 = d;
    endtask

    task automatic idle();
        req1(1'b0, 1'b0, 32'h0, 32'h0);
        req2(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        idle();

        // Reset: a pending request must not drive any strobe.
        req1(1'b1, 1'b0, 32'h10000000, 32'h0);
        req2(1'b1, 1'b1, 32'h10000004, 32'h99);
        #1;
        chk("rst_rd1", {31'h0, Mem_rd_1}, 32'h1);
        chk("rst_wr2", {31'h0, Mem_wr_2}, 32'h1);
        chk("rst_dir1", Dir_Mem_1, 32'h0);
        chk("rst_din2", Dato_Mem_in_2, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        tick();
        mem_init = 1'b0;
        chk("rst_rvalid1", {31'h0, rvalid_1}, 32'h0);
        chk("rst_rdata1", rdata_1, 32'h0);
        chk("rst_err2", {31'h0, addr_err_2}, 32'h0);
        rst = 1'b0;
        idle();
        $display("txn reset");

        // Load/load to different words: same cycle, no stall.
        req1(1'b1, 1'b0, 32'h10000000, 32'h0);
        req2(1'b1, 1'b0, 32'h10000004, 32'h0);
        #1;
        chk("ll_rd1", {31'h0, Mem_rd_1}, 32'h0);
        chk("ll_rd2", {31'h0, Mem_rd_2}, 32'h0);
        chk("ll_wr1", {31'h0, Mem_wr_1}, 32'h1);
        chk("ll_stall", {31'h0, stall}, 32'h0);
        chk("ll_dir2", Dir_Mem_2, 32'h10000004);
        tick();
        idle();
        chk("ll_rvalid1", {31'h0, rvalid_1}, 32'h1);
        chk("ll_rvalid2", {31'h0, rvalid_2}, 32'h1);
        chk("ll_rdata1", rdata_1, 32'h8);
        chk("ll_rdata2", rdata_2, 32'hD);
        tick();
        chk("ll_rvalid1_drop", {31'h0, rvalid_1}, 32'h0);
        chk("ll_rdata1_hold", rdata_1, 32'h8);
        $display("txn load/load 0x10000000 0x10000004 rdata=%h/%h", 32'h8, 32'hD);

        // Store then load, same word: split, load sees the new value.
        req1(1'b1, 1'b1, 32'h10000008, 32'h55);
        req2(1'b1, 1'b0, 32'h10000008, 32'h0);
        #1;
        chk("sl_wr1", {31'h0, Mem_wr_1}, 32'h0);
        chk("sl_din1", Dato_Mem_in_1, 32'h55);
        chk("sl_stall", {31'h0, stall}, 32'h1);
        chk("sl_rd2_n", {31'h0, Mem_rd_2}, 32'h1);
        chk("sl_wr2_n", {31'h0, Mem_wr_2}, 32'h1);
        tick();
        chk("sl_split_rd2", {31'h0, Mem_rd_2}, 32'h0);
        chk("sl_split_wr1", {31'h0, Mem_wr_1}, 32'h1);
        chk("sl_split_stall", {31'h0, stall}, 32'h0);
        chk("sl_split_dir2", Dir_Mem_2, 32'h10000008);
        chk("sl_split_dir1", Dir_Mem_1, 32'h0);
        tick();
        idle();
        chk("sl_rvalid2", {31'h0, rvalid_2}, 32'h1);
        chk("sl_rdata2", rdata_2, 32'h55);
        chk("sl_rvalid1", {31'h0, rvalid_1}, 32'h0);
        #1;
        chk("sl_back_idle_stall", {31'h0, stall}, 32'h0);
        $display("txn store/load 0x10000008 rdata2=%h", 32'h55);

        // Store then store, same word: pipe-2 data wins.
        req1(1'b1, 1'b1, 32'h1000000C, 32'hAA);
        req2(1'b1, 1'b1, 32'h1000000C, 32'hBB);
        #1;
        chk("ss_stall", {31'h0, stall}, 32'h1);
        chk("ss_wr1", {31'h0, Mem_wr_1}, 32'h0);
        chk("ss_wr2_n", {31'h0, Mem_wr_2}, 32'h1);
        tick();
        chk("ss_split_wr2", {31'h0, Mem_wr_2}, 32'h0);
        chk("ss_split_din2", Dato_Mem_in_2, 32'hBB);
        chk("ss_split_wr1", {31'h0, Mem_wr_1}, 32'h1);
        chk("ss_split_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();
        req1(1'b1, 1'b0, 32'h1000000C, 32'h0);
        #1;
        chk("ss_chk_rd1", {31'h0, Mem_rd_1}, 32'h0);
        tick();
        idle();
        chk("ss_rdata1", rdata_1, 32'hBB);
        chk("ss_rvalid1", {31'h0, rvalid_1}, 32'h1);
        $display("txn store/store 0x1000000C mem=%h", 32'hBB);

        // Bad addresses: out of window and misaligned.
        req1(1'b1, 1'b0, 32'h10000010, 32'h0);
        req2(1'b1, 1'b0, 32'h10000002, 32'h0);
        #1;
        chk("bad_rd1", {31'h0, Mem_rd_1}, 32'h1);
        chk("bad_rd2", {31'h0, Mem_rd_2}, 32'h1);
        chk("bad_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();
        chk("bad_err1", {31'h0, addr_err_1}, 32'h1);
        chk("bad_err2", {31'h0, addr_err_2}, 32'h1);
        chk("bad_rvalid1", {31'h0, rvalid_1}, 32'h0);
        chk("bad_rvalid2", {31'h0, rvalid_2}, 32'h0);
        tick();
        chk("bad_err1_drop", {31'h0, addr_err_1}, 32'h0);
        $display("txn bad addr 0x10000010 0x10000002");

        // Load/load to the same word: no conflict.
        req1(1'b1, 1'b0, 32'h10000004, 32'h0);
        req2(1'b1, 1'b0, 32'h10000004, 32'h0);
        #1;
        chk("same_stall", {31'h0, stall}, 32'h0);
        chk("same_rd1", {31'h0, Mem_rd_1}, 32'h0);
        chk("same_rd2", {31'h0, Mem_rd_2}, 32'h0);
        tick();
        idle();
        chk("same_rdata1", rdata_1, 32'hD);
        chk("same_rdata2", rdata_2, 32'hD);
        chk("same_rvalid2", {31'h0, rvalid_2}, 32'h1);
        $display("txn load/load same 0x10000004 rdata=%h", 32'hD);

        // Reset during SPLIT abandons the pending pipe-2 request.
        req1(1'b1, 1'b1, 32'h10000000, 32'h77);
        req2(1'b1, 1'b0, 32'h10000000, 32'h0);
        #1;
        chk("rs_stall", {31'h0, stall}, 32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk("rs_rd2", {31'h0, Mem_rd_2}, 32'h1);
        chk("rs_dir2", Dir_Mem_2, 32'h0);
        chk("rs_stall_rst", {31'h0, stall}, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        chk("rs_rvalid2", {31'h0, rvalid_2}, 32'h0);
        chk("rs_rdata1", rdata_1, 32'h0);
        chk("rs_rdata2", rdata_2, 32'h0);
        // Back in IDLE: a pipe-1 load issues on port 1 immediately.
        req1(1'b1, 1'b0, 32'h10000000, 32'h0);
        #1;
        chk("rs_idle_rd1", {31'h0, Mem_rd_1}, 32'h0);
        chk("rs_idle_stall", {31'h0, stall}, 32'h0);
        tick();
        idle();
        chk("rs_after_rdata1", rdata_1, 32'h77);
        $display("txn reset during split");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
